// File: rtl/ysyx_23060240_lsu.sv
// ysyx_23060240_lsu: load/store unit bridging EXU requests to a valid/ready memory bus
// with byte-lane steering, load extension and misaligned/illegal/timeout detection.
module ysyx_23060240_lsu #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  rd_ctrl,
   input  logic [7:0]  wr_ctrl,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
   localparam logic [31:0] TO = TIMEOUT;
   state_t state;
   logic [2:0] rd_q;
   logic [1:0] off_q;
   logic [31:0] cnt;
   logic illegal, misaligned, timeout;
   logic [7:0] b;
   logic [15:0] h;
   logic [31:0] load, wdata_sh;
   logic [3:0] wmask_n;
   always_comb begin
      illegal = (rd_ctrl != 3'd0 && wr_ctrl != 8'd0) || (rd_ctrl == 3'd0 && wr_ctrl == 8'd0) ||
                rd_ctrl >= 3'd6 || wr_ctrl > 8'd3;
      misaligned = ((rd_ctrl == 3'd3 || rd_ctrl == 3'd4 || wr_ctrl == 8'd2) && addr[0]) ||
                   ((rd_ctrl == 3'd5 || wr_ctrl == 8'd3) && addr[1:0] != 2'd0);
      timeout = TO != 32'd0 && cnt + 32'd1 == TO;
      b = mem_rdata[{off_q, 3'b000} +: 8];
      h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load = rd_q == 3'd1 ? {{24{b[7]}}, b} :
             rd_q == 3'd2 ? {24'd0, b} :
             rd_q == 3'd3 ? {{16{h[15]}}, h} :
             rd_q == 3'd4 ? {16'd0, h} :
             rd_q == 3'd5 ? mem_rdata : 32'd0;
      wdata_sh = wdata << {addr[1:0], 3'b000};
      wmask_n = wr_ctrl == 8'd1 ? 4'b0001 << addr[1:0] :
                wr_ctrl == 8'd2 ? 4'b0011 << addr[1:0] :
                wr_ctrl == 8'd3 ? 4'b1111 : 4'b0000;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         req_ready <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_addr <= 32'd0;
         mem_wen <= 1'b0;
         mem_wdata <= 32'd0;
         mem_wmask <= 4'd0;
         rd_q <= 3'd0;
         off_q <= 2'd0;
         cnt <= 32'd0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               req_ready <= 1'b0;
               rd_q <= rd_ctrl;
               off_q <= addr[1:0];
               cnt <= 32'd0;
               if (illegal || misaligned) begin
                  state <= RESP;
                  resp_valid <= 1'b1;
                  resp_err <= 1'b1;
                  resp_rdata <= 32'd0;
               end else begin
                  state <= REQ;
                  mem_req_valid <= 1'b1;
                  mem_addr <= {addr[31:2], 2'b00};
                  mem_wen <= wr_ctrl != 8'd0;
                  mem_wdata <= wdata_sh;
                  mem_wmask <= wmask_n;
               end
            end
            REQ: begin
               cnt <= cnt + 32'd1;
               if (timeout) begin
                  state <= RESP;
                  mem_req_valid <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err <= 1'b1;
                  resp_rdata <= 32'd0;
               end else if (mem_req_ready) begin
                  state <= WAIT;
                  mem_req_valid <= 1'b0;
               end
            end
            WAIT: begin
               cnt <= cnt + 32'd1;
               // a response arriving in the final allowed cycle still counts as success
               if (mem_resp_valid || timeout) begin
                  state <= RESP;
                  resp_valid <= 1'b1;
                  resp_err <= !mem_resp_valid;
                  resp_rdata <= mem_resp_valid ? load : 32'd0;
               end
            end
            RESP: begin
               state <= IDLE;
               req_ready <= 1'b1;
               resp_valid <= 1'b0;
               resp_err <= 1'b0;
               resp_rdata <= 32'd0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_23060240_lsu.sv
// tb_ysyx_23060240_lsu: directed bench with a transaction-level reference model
// and a per-cycle compare process, plus literal checks on the documented examples.
module tb_ysyx_23060240_lsu;
   localparam int TO = 8;
   logic clk = 1'b0, rst = 1'b1;
   logic req_valid = 1'b0, req_ready;
   logic [2:0] rd_ctrl = '0;
   logic [7:0] wr_ctrl = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic mem_req_valid, mem_wen;
   logic mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic [3:0] mem_wmask;
   int total = 0, passed = 0;
   bit chk_en = 0;
   logic exp_ready = 1'b1, exp_mreq = 1'b0, exp_resp = 1'b0, exp_err = 1'b0, exp_wen = 1'b0;
   logic [31:0] exp_rdata = '0, exp_baddr = '0, exp_wdata = '0;
   logic [3:0] exp_wmask = '0;
   logic [31:0] last_rdata, last_maddr, last_wdata;
   logic [3:0] last_wmask;
   logic last_err, last_rv;
   int last_lat;

   ysyx_23060240_lsu #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .rd_ctrl(rd_ctrl), .wr_ctrl(wr_ctrl), .addr(addr), .wdata(wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference: operation size, legality and lane arithmetic straight from the ISA rules
   function automatic void model(input logic [2:0] rd, input logic [7:0] wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rdat, output logic err,
                                 output logic [31:0] res, output logic [3:0] m, output logic [31:0] wsh);
      int sz, off;
      logic [31:0] v, msk;
      sz = (rd == 1 || rd == 2 || wr == 1) ? 1 : (rd == 3 || rd == 4 || wr == 2) ? 2 :
           (rd == 5 || wr == 3) ? 4 : 0;
      off = int'(a % 4);
      err = !(((rd != 0) != (wr != 0)) && rd <= 5 && wr <= 3 && sz > 0) || (sz > 0 && (a % sz) != 0);
      v = rdat >> (8 * off);
      msk = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
      v = v & msk;
      if ((rd == 1 || rd == 3) && sz > 0 && v[8*sz-1]) v = v | ~msk;
      res = (err || wr != 0) ? 32'd0 : v;
      m = (wr != 0 && !err) ? 4'(((1 << sz) - 1) << off) : 4'd0;
      wsh = wd << (8 * off);
   endfunction

   always @(negedge clk) if (chk_en) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, exp_mreq});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_resp});
      if (exp_mreq) begin
         chk("mem_addr", mem_addr, exp_baddr);
         chk("mem_wen", {31'd0, mem_wen}, {31'd0, exp_wen});
         chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, exp_wmask});
         if (exp_wen) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (exp_resp) begin
         chk("resp_rdata", resp_rdata, exp_rdata);
         chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
      end
   end

   // rsp_dly < 0 means the bus never answers
   task automatic run(input logic [2:0] rd, input logic [7:0] wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rdat, input int rdy_dly, input int rsp_dly);
      logic err;
      logic [31:0] res, wsh;
      logic [3:0] m;
      int hs, rc, lat;
      bit done;
      model(rd, wr, a, wd, rdat, err, res, m, wsh);
      rd_ctrl = rd; wr_ctrl = wr; addr = a; wdata = wd; req_valid = 1'b1;
      exp_baddr = {a[31:2], 2'b00}; exp_wen = wr != 0; exp_wmask = m; exp_wdata = wsh;
      step();
      req_valid = 1'b0; rd_ctrl = '0; wr_ctrl = '0;
      exp_ready = 1'b0;
      lat = 1;
      if (!err) begin
         hs = 1 + rdy_dly;
         rc = rsp_dly < 0 ? -1 : hs + rsp_dly;
         done = 0;
         for (int c = 1; c <= 64; c++) begin
            exp_mreq = c <= hs;
            mem_req_ready = c == hs;
            mem_resp_valid = c == rc;
            mem_rdata = rdat;
            if (c == 1) begin
               #2;
               last_maddr = mem_addr; last_wmask = mem_wmask; last_wdata = mem_wdata;
            end
            step();
            lat = c + 1;
            if (c == rc) begin done = 1; break; end
            if (c == TO) begin err = 1'b1; res = '0; done = 1; break; end
         end
         if (!done) chk("bus_bound", 32'd0, 32'd1);
      end
      exp_mreq = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      exp_resp = 1'b1; exp_err = err; exp_rdata = res;
      #2;
      last_rdata = resp_rdata; last_err = resp_err; last_rv = resp_valid; last_lat = lat;
      step();
      exp_resp = 1'b0; exp_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_outs", {28'd0, resp_valid, resp_err, mem_req_valid, mem_wen}, 32'd0);
      chk("rst_data", resp_rdata | mem_addr | mem_wdata | {28'd0, mem_wmask}, 32'd0);
      chk_en = 1;
      run(3'd1, 8'h00, 32'h8000_0003, 32'd0, 32'h80FF_1234, 0, 1);
      chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
      chk("lb_maddr", last_maddr, 32'h8000_0000);
      chk("lb_wmask", {28'd0, last_wmask}, 32'd0);
      chk("lb_err", {31'd0, last_err}, 32'd0);
      chk("lb_latency", last_lat, 32'd3);
      run(3'd4, 8'h00, 32'h8000_0002, 32'd0, 32'hBEEF_0000, 0, 1);
      chk("lhu_rdata", last_rdata, 32'h0000_BEEF);
      run(3'd3, 8'h00, 32'h8000_0002, 32'd0, 32'hBEEF_0000, 1, 2);
      chk("lh_rdata", last_rdata, 32'hFFFF_BEEF);
      run(3'd0, 8'h01, 32'h10, 32'hAB, 32'd0, 0, 1);
      chk("sb0_wmask", {28'd0, last_wmask}, 32'h1);
      chk("sb0_wdata", last_wdata, 32'h0000_00AB);
      chk("sb0_rdata", last_rdata, 32'd0);
      run(3'd0, 8'h01, 32'h13, 32'hAB, 32'd0, 0, 1);
      chk("sb3_wmask", {28'd0, last_wmask}, 32'h8);
      chk("sb3_wdata", last_wdata, 32'hAB00_0000);
      run(3'd0, 8'h03, 32'h102, 32'h1234_5678, 32'd0, 0, 1);
      chk("sw_mis_valid", {31'd0, last_rv}, 32'd1);
      chk("sw_mis_err", {31'd0, last_err}, 32'd1);
      chk("sw_mis_rdata", last_rdata, 32'd0);
      chk("sw_mis_latency", last_lat, 32'd1);
      run(3'd5, 8'h00, 32'h20, 32'd0, 32'hDEAD_BEEF, 3, 1);
      chk("lw_stall_rdata", last_rdata, 32'hDEAD_BEEF);
      chk("lw_stall_latency", last_lat, 32'd6);
      run(3'd5, 8'h00, 32'h24, 32'd0, 32'h1111_1111, 0, -1);
      chk("timeout_err", {31'd0, last_err}, 32'd1);
      chk("timeout_latency", last_lat, 32'd9);
      chk("timeout_rdata", last_rdata, 32'd0);
      run(3'd0, 8'h02, 32'h22, 32'h1234, 32'd0, 2, 3);
      chk("sh_wmask", {28'd0, last_wmask}, 32'hC);
      chk("sh_wdata", last_wdata, 32'h1234_0000);
      run(3'd2, 8'h00, 32'h81, 32'd0, 32'h1234_F0AB, 0, 1);
      chk("lbu_rdata", last_rdata, 32'h0000_00F0);
      run(3'd0, 8'h03, 32'h200, 32'h55AA_55AA, 32'd0, 1, 4);
      run(3'd1, 8'h01, 32'h0, 32'd0, 32'd0, 0, 1);
      chk("both_ctrl_err", {31'd0, last_err}, 32'd1);
      run(3'd6, 8'h00, 32'h0, 32'd0, 32'd0, 0, 1);
      run(3'd0, 8'h04, 32'h0, 32'd0, 32'd0, 0, 1);
      run(3'd0, 8'h00, 32'h0, 32'd0, 32'd0, 0, 1);
      run(3'd3, 8'h00, 32'h81, 32'd0, 32'd0, 0, 1);
      chk("lh_mis_err", {31'd0, last_err}, 32'd1);
      run(3'd5, 8'h00, 32'h30, 32'd0, 32'hCAFE_F00D, 2, 5);
      // reset while waiting for the bus: transaction abandoned, late response ignored
      rd_ctrl = 3'd5; addr = 32'h40; req_valid = 1'b1;
      exp_baddr = 32'h40; exp_wen = 1'b0; exp_wmask = 4'd0;
      step();
      req_valid = 1'b0; rd_ctrl = '0; exp_ready = 1'b0; exp_mreq = 1'b1; mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0; exp_mreq = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0; exp_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
      step();
      mem_resp_valid = 1'b0;
      chk("rst_wait_no_resp", {31'd0, resp_valid}, 32'd0);
      step();
      step();
      run(3'd5, 8'h00, 32'h44, 32'd0, 32'h0BAD_CAFE, 0, 1);
      chk("post_rst_lw", last_rdata, 32'h0BAD_CAFE);
      chk_en = 0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
